route_tap: RTL and testbench

Parametrised multi-channel capture tap for routed signals. Takes CHANNELS routed buses of WIDTH bits, retimes them through PRE_STAGES register stages, keeps a previous-sample copy for edge detection, and, once armed and triggered, captures DEPTH consecutive samples into an internal buffer. Firmware or a debug master reads the buffer out sequentially. Instances are dropped anywhere in the hierarchy as an in-design logic analyzer on signals routed to them.

---
 rtl/route_tap_pkg.sv | 22 ++
 rtl/route_tap_trig.sv | 50 +++++
 rtl/route_tap.sv | 168 ++++++++++++++++
 tb/tb_route_tap.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/route_tap_pkg.sv
// Shared types and constants for the route_tap capture block: state encoding,
// trigger mode codes and the trigger-channel select width helper.
package route_tap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      CAPTURE = 2'b10,
      DONE    = 2'b11
   } tap_state_t;

   localparam logic [1:0] TRIG_MATCH  = 2'b00;
   localparam logic [1:0] TRIG_RISE   = 2'b01;
   localparam logic [1:0] TRIG_FALL   = 2'b10;
   localparam logic [1:0] TRIG_CHANGE = 2'b11;

   // width of a channel index; never narrower than one bit
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/route_tap_trig.sv
// Combinational trigger evaluator: selects one channel from the current and
// previous retimed samples and applies mode, mask and compare value.
module route_tap_trig
   import route_tap_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
)(
   input  logic [CHANNELS*WIDTH-1:0]       s,
   input  logic [CHANNELS*WIDTH-1:0]       p1,
   input  logic                            prev_ok,
   input  logic [sel_width(CHANNELS)-1:0]  trig_ch,
   input  logic [1:0]                      trig_mode,
   input  logic [WIDTH-1:0]                trig_mask,
   input  logic [WIDTH-1:0]                trig_value,
   output logic                            fire
);

   logic [WIDTH-1:0] s_sel;
   logic [WIDTH-1:0] p_sel;
   logic             ch_ok;

   // channel mux; an index beyond the last channel leaves ch_ok low
   always_comb begin
      s_sel = '0;
      p_sel = '0;
      ch_ok = 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (32'(trig_ch) == k) begin
            s_sel = s[k*WIDTH +: WIDTH];
            p_sel = p1[k*WIDTH +: WIDTH];
            ch_ok = 1'b1;
         end
      end
   end

   // mode evaluation; edge modes need a valid previous sample
   always_comb begin
      fire = 1'b0;
      if (ch_ok) begin
         case (trig_mode)
            TRIG_MATCH:  fire = ((s_sel ^ trig_value) & trig_mask) == '0;
            TRIG_RISE:   fire = prev_ok && (|(~p_sel & s_sel & trig_mask));
            TRIG_FALL:   fire = prev_ok && (|(p_sel & ~s_sel & trig_mask));
            TRIG_CHANGE: fire = prev_ok && (|((s_sel ^ p_sel) & trig_mask));
         endcase
      end
   end

endmodule

// File: rtl/route_tap.sv
// route_tap: multi-channel in-design logic analyzer. Retimes CHANNELS routed
// buses, triggers on one channel and captures DEPTH samples for sequential
// readout. Optional pre-trigger ring capture: define ROUTE_TAP_PRETRIG_EN.
module route_tap
   import route_tap_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int PRE_STAGES = 2
)(
   input  logic                            clk,
   input  logic                            reset,
   input  logic [CHANNELS*WIDTH-1:0]       ch_in,
   input  logic                            arm,
   input  logic                            abort,
   input  logic [sel_width(CHANNELS)-1:0]  trig_ch,
   input  logic [1:0]                      trig_mode,
   input  logic [WIDTH-1:0]                trig_mask,
   input  logic [WIDTH-1:0]                trig_value,
   input  logic                            rd_en,
   output logic [CHANNELS*WIDTH-1:0]       rd_data,
   output logic                            rd_valid,
   output logic [1:0]                      state,
   output logic                            done
);

   localparam int DW = CHANNELS*WIDTH;
   localparam int AW = $clog2(DEPTH);

`ifdef ROUTE_TAP_PRETRIG_EN
   localparam bit PRETRIG = 1'b1;
`else
   localparam bit PRETRIG = 1'b0;
`endif

   // count value on the write that completes the capture (trigger write = 1)
   localparam logic [AW:0] LAST_WR = (AW+1)'(PRETRIG ? DEPTH/2 - 1 : DEPTH - 1);
   localparam logic [AW:0] LAST_RD = (AW+1)'(DEPTH - 1);

   logic [DW-1:0] pipe [PRE_STAGES];
   logic [DW-1:0] s;
   logic [DW-1:0] p1;
   logic [DW-1:0] mem [DEPTH];

   tap_state_t    st;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   wr_cnt;
   logic [AW:0]   rd_cnt;
   logic          prev_ok;
   logic          fire;
   logic          wr_en;

   // input retiming chain plus the one-cycle-old copy used for edge modes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < PRE_STAGES; i++) pipe[i] <= '0;
         p1 <= '0;
      end else begin
         pipe[0] <= ch_in;
         for (int unsigned i = 1; i < PRE_STAGES; i++) pipe[i] <= pipe[i-1];
         p1 <= pipe[PRE_STAGES-1];
      end
   end

   assign s     = pipe[PRE_STAGES-1];
   assign state = st;

   route_tap_trig #(
      .CHANNELS (CHANNELS),
      .WIDTH    (WIDTH)
   ) u_trig (
      .s          (s),
      .p1         (p1),
      .prev_ok    (prev_ok),
      .trig_ch    (trig_ch),
      .trig_mode  (trig_mode),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .fire       (fire)
   );

   // write strobe: trigger sample, capture run, and the pre-trigger ring
   always_comb begin
      wr_en = 1'b0;
      if (!abort) begin
         case (st)
            ARMED:   wr_en = PRETRIG || fire;
            CAPTURE: wr_en = 1'b1;
            default: wr_en = 1'b0;
         endcase
      end
   end

   // buffer write port; contents intentionally survive reset and abort
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= s;
   end

   // control FSM: arm, trigger, capture, readout; abort overrides everything
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st       <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         prev_ok  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         done     <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         prev_ok  <= 1'b0;
         if (abort) begin
            st     <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            done   <= 1'b0;
         end else begin
            case (st)
               IDLE: begin
                  wr_ptr <= '0;
                  rd_ptr <= '0;
                  wr_cnt <= '0;
                  rd_cnt <= '0;
                  if (arm) st <= ARMED;
               end
               ARMED: begin
                  prev_ok <= 1'b1;
                  if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                  if (fire) begin
                     st     <= CAPTURE;
                     wr_cnt <= (AW+1)'(1);
                  end
               end
               CAPTURE: begin
                  wr_ptr <= wr_ptr + AW'(1);
                  wr_cnt <= wr_cnt + (AW+1)'(1);
                  if (wr_cnt == LAST_WR) begin
                     // oldest entry sits just past the final write in both modes
                     st     <= DONE;
                     done   <= 1'b1;
                     rd_ptr <= wr_ptr + AW'(1);
                     rd_cnt <= '0;
                  end
               end
               DONE: begin
                  if (rd_en) begin
                     rd_data  <= mem[rd_ptr];
                     rd_valid <= 1'b1;
                     rd_ptr   <= rd_ptr + AW'(1);
                     rd_cnt   <= rd_cnt + (AW+1)'(1);
                     if (rd_cnt == LAST_RD) begin
                        st   <= IDLE;
                        done <= 1'b0;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_route_tap.sv
// Self-checking bench for route_tap (default parameters). Captured samples are
// predicted from the driven ch_in words and queued; readout pops and compares.
module tb_route_tap;

   localparam int CHANNELS   = 4;
   localparam int WIDTH      = 8;
   localparam int DEPTH      = 16;
   localparam int PRE_STAGES = 2;

   localparam logic [1:0] S_IDLE = 2'b00, S_ARMED = 2'b01, S_CAPT = 2'b10, S_DONE = 2'b11;
   localparam logic [1:0] M_MATCH = 2'b00, M_RISE = 2'b01, M_CHANGE = 2'b11;

   logic        clk;
   logic        reset;
   logic [31:0] ch_in;
   logic        arm;
   logic        abort;
   logic [1:0]  trig_ch;
   logic [1:0]  trig_mode;
   logic [7:0]  trig_mask;
   logic [7:0]  trig_value;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [1:0]  state;
   logic        done;

   logic [7:0]  cv [4];
   int          rec_left;
   logic [31:0] exp_q [$];
   int          checks;
   int          errors;

   route_tap #(
      .CHANNELS   (CHANNELS),
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .PRE_STAGES (PRE_STAGES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ch_in      (ch_in),
      .arm        (arm),
      .abort      (abort),
      .trig_ch    (trig_ch),
      .trig_mode  (trig_mode),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .state      (state),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive the channel word, record it if a capture is being predicted, then
   // advance one rising edge and land on the following falling edge
   task automatic clk_step();
      ch_in = {cv[3], cv[2], cv[1], cv[0]};
      if (rec_left > 0) begin
         exp_q.push_back(ch_in);
         rec_left--;
      end
      @(posedge clk);
      @(negedge clk);
      cv[0] = cv[0] + 8'd1;
      arm   = 1'b0;
      abort = 1'b0;
   endtask

   task automatic trig_capture(input string tag, input int ch, input logic [7:0] hit, input logic [7:0] rest);
      cv[ch]   = hit;
      rec_left = DEPTH;
      clk_step();
      cv[ch] = rest;
      check({tag, "_armed_1"}, 32'(state), 32'(S_ARMED));
      clk_step();
      check({tag, "_armed_2"}, 32'(state), 32'(S_ARMED));
      clk_step();
      check({tag, "_capture"}, 32'(state), 32'(S_CAPT));
      for (int i = 0; i < DEPTH - 2; i++) clk_step();
      check({tag, "_last_capt"}, 32'(state), 32'(S_CAPT));
      check({tag, "_done_lo"}, 32'(done), 32'd0);
      clk_step();
      check({tag, "_state_done"}, 32'(state), 32'(S_DONE));
      check({tag, "_done_hi"}, 32'(done), 32'd1);
   endtask

   task automatic readout(input string tag);
      logic [31:0] e;
      rd_en = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         clk_step();
         if (i < DEPTH) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check({tag, "_valid"}, 32'(rd_valid), 32'd1);
            check({tag, "_data"}, rd_data, e);
            if (i == DEPTH - 1) begin
               check({tag, "_idle_after_last"}, 32'(state), 32'(S_IDLE));
               check({tag, "_done_clr"}, 32'(done), 32'd0);
            end
         end else begin
            check({tag, "_extra_rd_ignored"}, 32'(rd_valid), 32'd0);
         end
      end
      rd_en = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; rec_left = 0;
      for (int i = 0; i < 4; i++) cv[i] = 8'h00;
      ch_in = '0; arm = 1'b0; abort = 1'b0; rd_en = 1'b0;
      trig_ch = 2'd0; trig_mode = M_MATCH; trig_mask = 8'hFF; trig_value = 8'h00;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      check("rst_state", 32'(state), 32'(S_IDLE));
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

`ifdef ROUTE_TAP_PRETRIG_EN
      // pre-trigger ring: trigger on counter value 40, expect 32..47 back
      trig_ch = 2'd0; trig_mode = M_MATCH; trig_mask = 8'hFF; trig_value = 8'd40;
      cv[0] = 8'd10;
      arm = 1'b1;
      clk_step();
      check("pre_armed", 32'(state), 32'(S_ARMED));
      for (int v = 32; v < 48; v++) exp_q.push_back({24'h0, 8'(v)});
      for (int i = 0; i < 80 && state != S_DONE; i++) clk_step();
      check("pre_done", 32'(done), 32'd1);
      readout("pre_rd");
`else
      // read request while idle must be ignored
      rd_en = 1'b1;
      clk_step();
      check("idle_rd_ignored", 32'(rd_valid), 32'd0);
      rd_en = 1'b0;

      // match on ch2 == 0x5A with a counter on ch0
      trig_ch = 2'd2; trig_mode = M_MATCH; trig_mask = 8'hFF; trig_value = 8'h5A;
      cv[0] = 8'd0;
      arm = 1'b1;
      clk_step();
      check("m_armed", 32'(state), 32'(S_ARMED));
      for (int i = 0; i < 8; i++) clk_step();
      check("m_still_armed", 32'(state), 32'(S_ARMED));
      trig_capture("m", 2, 8'h5A, 8'h00);
      readout("m_rd");

      // rise on ch1 bit0: line already high when armed, rising into first ARMED cycle
      trig_ch = 2'd1; trig_mode = M_RISE; trig_mask = 8'h01; trig_value = 8'h00;
      cv[1] = 8'h00;
      clk_step();
      clk_step();
      cv[1] = 8'h01;
      clk_step();
      arm = 1'b1;
      clk_step();
      check("r_armed", 32'(state), 32'(S_ARMED));
      clk_step();
      check("r_no_fire_first", 32'(state), 32'(S_ARMED));
      for (int i = 0; i < 4; i++) clk_step();
      check("r_held_high", 32'(state), 32'(S_ARMED));
      cv[1] = 8'h00;
      clk_step();
      cv[1] = 8'h01;
      clk_step();
      check("r_edge_armed_1", 32'(state), 32'(S_ARMED));
      clk_step();
      check("r_edge_armed_2", 32'(state), 32'(S_ARMED));
      clk_step();
      check("r_edge_capture", 32'(state), 32'(S_CAPT));

      // abort in place of the seventh capture write
      for (int i = 0; i < 5; i++) clk_step();
      check("ab_pre", 32'(state), 32'(S_CAPT));
      abort = 1'b1;
      clk_step();
      check("ab_idle", 32'(state), 32'(S_IDLE));
      check("ab_done", 32'(done), 32'd0);
      abort = 1'b1; arm = 1'b1;
      clk_step();
      check("ab_arm_same_cycle", 32'(state), 32'(S_IDLE));

      // zero mask: edge modes never fire even with a toggling channel
      trig_ch = 2'd0; trig_mode = M_CHANGE; trig_mask = 8'h00;
      arm = 1'b1;
      clk_step();
      for (int i = 0; i < 6; i++) clk_step();
      check("m0_change_armed", 32'(state), 32'(S_ARMED));
      abort = 1'b1;
      clk_step();
      check("m0_change_abort", 32'(state), 32'(S_IDLE));

      // zero mask: match fires on the first ARMED cycle
      trig_mode = M_MATCH; trig_mask = 8'h00;
      arm = 1'b1;
      clk_step();
      check("m0_match_armed", 32'(state), 32'(S_ARMED));
      clk_step();
      check("m0_match_fire", 32'(state), 32'(S_CAPT));
      abort = 1'b1;
      clk_step();
      check("m0_match_abort", 32'(state), 32'(S_IDLE));

      // fresh capture after abort, masked match on ch3 upper nibble
      trig_ch = 2'd3; trig_mode = M_MATCH; trig_mask = 8'hF0; trig_value = 8'hC3;
      cv[3] = 8'h00; cv[1] = 8'h5C;
      arm = 1'b1;
      clk_step();
      for (int i = 0; i < 3; i++) clk_step();
      check("f_armed", 32'(state), 32'(S_ARMED));
      trig_capture("f", 3, 8'hC7, 8'h07);
      readout("f_rd");

      // asynchronous reset in the middle of a capture
      trig_mode = M_MATCH; trig_mask = 8'h00;
      arm = 1'b1;
      clk_step();
      clk_step();
      clk_step();
      clk_step();
      check("rc_capture", 32'(state), 32'(S_CAPT));
      reset = 1'b0;
      #1;
      check("rc_state", 32'(state), 32'(S_IDLE));
      check("rc_done", 32'(done), 32'd0);
      check("rc_rd_valid", 32'(rd_valid), 32'd0);
      check("rc_rd_data", rd_data, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      arm = 1'b1;
      clk_step();
      check("rc_first_arm", 32'(state), 32'(S_ARMED));
      abort = 1'b1;
      clk_step();
      check("rc_abort", 32'(state), 32'(S_IDLE));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
